// File: rtl/tx_mod_pkg.sv
// tx_mod_pkg: shared definitions for the TinyWhisper TX modulator.
//   - Modulation mode codes carried on i_mode.
//   - Top-level FSM state encoding.
//   - First bit of the alternating preamble pattern.
package tx_mod_pkg;

    localparam logic [1:0] MODE_OOK  = 2'b00;
    localparam logic [1:0] MODE_FSK  = 2'b01;
    localparam logic [1:0] MODE_BPSK = 2'b10;
    localparam logic [1:0] MODE_CW   = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StData,
        StTail,
        StCw
    } state_e;

    // Preamble runs 1,0,1,0,... starting with this value.
    localparam logic PRE_FIRST_BIT = 1'b1;

endpackage

// File: rtl/tx_mod_nco.sv
// tx_nco: phase-accumulator NCO with square-wave output.
// Ports:
//   clk    system clock (rising edge)
//   rst_n  asynchronous active-low reset, clears the accumulator
//   clr    synchronous clear to phase 0 (has priority over en)
//   en     advance accumulator by fcw this clock
//   fcw    frequency control word
//   msb    accumulator MSB, i.e. the square-wave carrier
module tx_nco #(
    parameter int unsigned ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [ACC_W-1:0] fcw,
    output logic             msb
);

    logic [ACC_W-1:0] acc_q;

    // Wraps naturally modulo 2^ACC_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + fcw;
        end
    end

    assign msb = acc_q[ACC_W-1];

endmodule

// File: rtl/tx_mod.sv
// tx_mod: TinyWhisper TX carrier modulator.
// Serialises bytes LSB first after an optional 1010 preamble and modulates an NCO
// square-wave carrier with OOK, 2-FSK, BPSK or plain CW.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_enable             block enable; low aborts to IDLE
//   i_mode               00 OOK, 01 FSK, 10 BPSK, 11 CW
//   i_fcw0, i_fcw1       NCO words for space/nominal and FSK mark
//   i_baud_div           clocks per bit minus 1
//   i_pre_len            preamble length in bytes (0 = none)
//   i_data/i_valid       byte handshake in, o_ready back
//   o_busy               FSM not idle
//   o_pa_en, o_tx_p/n    PA enable and complementary carrier pair (registered)
//   o_bit                current symbol bit (registered, debug)
module tx_mod
    import tx_mod_pkg::*;
#(
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned BAUD_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic [1:0]        i_mode,
    input  logic [ACC_W-1:0]  i_fcw0,
    input  logic [ACC_W-1:0]  i_fcw1,
    input  logic [BAUD_W-1:0] i_baud_div,
    input  logic [3:0]        i_pre_len,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_pa_en,
    output logic              o_tx_p,
    output logic              o_tx_n,
    output logic              o_bit
);

    state_e            state_q;
    logic [7:0]        shift_q;
    logic [7:0]        hold_q;
    logic              hold_full_q;
    logic [BAUD_W-1:0] baud_ctr_q;
    logic [6:0]        bit_cnt_q;
    logic              tx_p_q, tx_n_q, pa_en_q, bit_q;

    logic             bit_tick;
    logic             sym_bit;
    logic             carrier;
    logic             mod_bit;
    logic             pa_on;
    logic             accept;
    logic [ACC_W-1:0] fcw;
    logic [6:0]       pre_last;

    assign bit_tick = (baud_ctr_q == '0);
    // Index of the final preamble bit: 8*i_pre_len - 1.
    assign pre_last = {i_pre_len - 4'd1, 3'b111};

    always_comb begin
        sym_bit = 1'b0;
        case (state_q)
            StPre:   sym_bit = PRE_FIRST_BIT ^ bit_cnt_q[0];
            StData:  sym_bit = shift_q[0];
            default: sym_bit = 1'b0;
        endcase
    end

    assign fcw = (i_mode == MODE_FSK && sym_bit) ? i_fcw1 : i_fcw0;

    // Accumulator is held at 0 in IDLE so every transmission starts at phase 0.
    tx_nco #(
        .ACC_W (ACC_W)
    ) u_nco (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (state_q == StIdle),
        .en    (1'b1),
        .fcw   (fcw),
        .msb   (carrier)
    );

    always_comb begin
        mod_bit = 1'b0;
        case (state_q)
            StPre, StData: begin
                case (i_mode)
                    MODE_OOK:  mod_bit = carrier & sym_bit;
                    MODE_BPSK: mod_bit = carrier ^ ~sym_bit;
                    default:   mod_bit = carrier;
                endcase
            end
            StCw:    mod_bit = carrier;
            default: mod_bit = 1'b0;
        endcase
    end

    assign pa_on = (state_q != StIdle);

    // CW never consumes bytes, so the holding register is closed while CW is selected.
    assign o_ready = ~hold_full_q & i_enable & (state_q != StCw) & (i_mode != MODE_CW);
    assign accept  = i_valid & o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            baud_ctr_q  <= '0;
            bit_cnt_q   <= '0;
            tx_p_q      <= 1'b0;
            tx_n_q      <= 1'b0;
            pa_en_q     <= 1'b0;
            bit_q       <= 1'b0;
        end else begin
            tx_p_q  <= mod_bit;
            tx_n_q  <= pa_on & ~mod_bit;
            pa_en_q <= pa_on;
            bit_q   <= sym_bit;

            if (!i_enable) begin
                state_q     <= StIdle;
                hold_full_q <= 1'b0;
                baud_ctr_q  <= i_baud_div;
                bit_cnt_q   <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        baud_ctr_q <= i_baud_div;
                        bit_cnt_q  <= '0;
                        if (i_mode == MODE_CW) begin
                            state_q <= StCw;
                        end else if (hold_full_q) begin
                            if (i_pre_len != 4'd0) begin
                                state_q <= StPre;
                            end else begin
                                state_q     <= StData;
                                shift_q     <= hold_q;
                                hold_full_q <= 1'b0;
                            end
                        end
                    end
                    StPre: begin
                        if (bit_tick) begin
                            baud_ctr_q <= i_baud_div;
                            if (bit_cnt_q == pre_last) begin
                                bit_cnt_q   <= '0;
                                shift_q     <= hold_q;
                                hold_full_q <= 1'b0;
                                state_q     <= StData;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 7'd1;
                            end
                        end else begin
                            baud_ctr_q <= baud_ctr_q - BAUD_W'(1);
                        end
                    end
                    StData: begin
                        if (bit_tick) begin
                            baud_ctr_q <= i_baud_div;
                            shift_q    <= shift_q >> 1;
                            if (bit_cnt_q == 7'd7) begin
                                bit_cnt_q <= '0;
                                // Chain the next byte with no gap bit.
                                if (hold_full_q) begin
                                    shift_q     <= hold_q;
                                    hold_full_q <= 1'b0;
                                end else begin
                                    state_q <= StTail;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 7'd1;
                            end
                        end else begin
                            baud_ctr_q <= baud_ctr_q - BAUD_W'(1);
                        end
                    end
                    StTail: begin
                        if (bit_tick) begin
                            baud_ctr_q <= i_baud_div;
                            state_q    <= StIdle;
                        end else begin
                            baud_ctr_q <= baud_ctr_q - BAUD_W'(1);
                        end
                    end
                    StCw: begin
                        baud_ctr_q <= i_baud_div;
                        if (i_mode != MODE_CW) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end

            if (accept) begin
                hold_q      <= i_data;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign o_busy  = (state_q != StIdle);
    assign o_pa_en = pa_en_q;
    assign o_tx_p  = tx_p_q;
    assign o_tx_n  = tx_n_q;
    assign o_bit   = bit_q;

endmodule
